move_command_encoder: RTL and testbench
=======================================

Name: move_command_encoder

Overview:
- Front end for the 2048 game's player inputs: conditions the five raw push-buttons (start, left, right, up, down) and emits one move/start command per press to the game control FSM over a valid/ready handshake.
- Sits between the board KEY/GPIO pins and the game FSM, in the 50 MHz domain.
- Produces exactly one command per debounced press, so a held or bouncing button never causes repeated moves.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (20 ms at 50 MHz); must be ≥2.
- CNT_W, 20, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- BTN_ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed; 0 = reads 1 when pressed.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- btn_start  in  1  raw start button, asynchronous to clk.
- btn_left  in  1  raw left button, asynchronous.
- btn_right  in  1  raw right button, asynchronous.
- btn_up  in  1  raw up button, asynchronous.
- btn_down  in  1  raw down button, asynchronous.
- cmd_ready  in  1  game FSM accepts the command this cycle.
- cmd_valid  out  1  command pending.
- cmd_code  out  3  0 none, 1 left, 2 right, 3 up, 4 down, 5 start; 6 and 7 are never driven.
- cmd_dropped  out  1  one-cycle pulse: a press was discarded.
- btn_level  out  5  debounced pressed levels {start, up, down, left, right}, 1 = pressed.

Behaviour:
- Reset (rst=0, asynchronous): cmd_valid=0, cmd_code=0, cmd_dropped=0, btn_level=0.
  - Synchronizer flops, stable states and edge-history flops are set to "released".
  - Debounce counters are cleared and the FSM returns to IDLE.
  - Any pending command is lost. Release of rst is synchronous to clk.
- Polarity: raw inputs are normalised to pressed=1 per BTN_ACTIVE_LOW before synchronization.
- Synchronizer: 2-flop synchronizer per button.
- Debounce, per button:
  - Counter clears on any cycle where the synchronized value equals the stable value.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 and the values still differ, the stable value takes the synchronized value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes the stable value. Press and release are debounced identically.
- Press event: stable value goes from 0 to 1. Releases generate no command.
- Priority when several press events occur in the same cycle: start > up > down > left > right. Only the winner is encoded; the losers assert cmd_dropped for that cycle.
- FSM:
  - IDLE: on a press event, register cmd_code and set cmd_valid=1 on the next edge, then go to PENDING.
  - PENDING: cmd_valid and cmd_code are held stable.
    - When cmd_valid=1 and cmd_ready=1 at a rising edge, the command transfers. The FSM goes to IDLE and cmd_valid=0 and cmd_code=0 from the next cycle.
    - A press event arriving while in PENDING (including the transfer cycle) is discarded and cmd_dropped pulses for one cycle.
- cmd_ready is ignored in IDLE. cmd_valid never deasserts without a transfer, except on reset.
- Latency: a raw press applied before edge 1 and held gives stable=1 at edge 2+DEBOUNCE_CYCLES and cmd_valid=1 after edge 3+DEBOUNCE_CYCLES.
- btn_level mirrors the stable values with zero added latency.
- Back-to-back presses: a new command may enter IDLE in the cycle immediately after a transfer.

Test Plan:
1. DEBOUNCE_CYCLES=4, BTN_ACTIVE_LOW=1. Drive btn_left 1→0 and hold, cmd_ready=0 → cmd_valid=1 and cmd_code=1 after edge 7, held for 20 cycles. Raise cmd_ready for 1 cycle → cmd_valid=0 and cmd_code=0 next cycle. No second command while btn_left stays low.
2. Bounce: btn_up toggles low/high every 2 cycles for 12 cycles, then settles low → exactly one command, cmd_code=3, at edge 7 counted from the final settle. btn_level[3] rises once.
3. Simultaneous: btn_start and btn_down both fall before the same edge → cmd_code=5, and cmd_dropped=1 for exactly one cycle in the press-event cycle.
4. Busy drop: with cmd_code=2 pending and cmd_ready=0, press btn_down → cmd_dropped pulses once, cmd_code stays 2. After ready, no down command appears.
5. Reset mid-operation: with cmd_valid=1 pending, pulse rst=0 between clock edges → outputs 0 immediately. After release, a still-held button produces no command until it is released and pressed again.
6. Release only: a button held since reset, then released → btn_level falls after DEBOUNCE_CYCLES+2 edges, and cmd_valid stays 0.

Source files
------------

// File: rtl/move_command_encoder.sv
// move_command_encoder: synchronizes and debounces five push-buttons and issues one
// move/start command per debounced press over a valid/ready handshake.
module move_command_encoder #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       cmd_dropped,
    output logic [4:0] btn_level
);
    typedef enum logic {IDLE, PENDING} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [4:0] raw, meta, sync, stable, prev, armed, press;
    logic [CNT_W-1:0] cnt [5];
    logic [1:0] warm;
    logic [2:0] code, code_n, win;
    state_t state, state_n;

    assign raw = {btn_start, btn_up, btn_down, btn_left, btn_right} ^ {5{BTN_ACTIVE_LOW}};

    // A button becomes eligible for press events only once it has been seen released
    // after reset (warm marks the synchronizer holding real samples), so a button held
    // through reset is absorbed silently.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta   <= '0;
            sync   <= '0;
            stable <= '0;
            prev   <= '0;
            armed  <= '0;
            warm   <= '0;
            for (int b = 0; b < 5; b++) cnt[b] <= '0;
        end else begin
            meta  <= raw;
            sync  <= meta;
            prev  <= stable;
            warm  <= {warm[0], 1'b1};
            armed <= armed | ({5{warm[1]}} & ~sync & ~stable);
            for (int b = 0; b < 5; b++) begin
                if (sync[b] == stable[b]) begin
                    cnt[b] <= '0;
                end else if (cnt[b] == LAST) begin
                    stable[b] <= sync[b];
                    cnt[b]    <= '0;
                end else begin
                    cnt[b] <= cnt[b] + CNT_W'(1);
                end
            end
        end
    end

    assign press = stable & ~prev & armed;
    assign win = press[4] ? 3'd5 : press[3] ? 3'd3 : press[2] ? 3'd4 :
                 press[1] ? 3'd1 : press[0] ? 3'd2 : 3'd0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            code  <= '0;
        end else begin
            state <= state_n;
            code  <= code_n;
        end
    end

    always_comb begin
        state_n     = state;
        code_n      = code;
        cmd_dropped = 1'b0;
        if (state == IDLE) begin
            cmd_dropped = |(press & (press - 5'd1));
            if (|press) begin
                state_n = PENDING;
                code_n  = win;
            end
        end else begin
            cmd_dropped = |press;
            if (cmd_ready) begin
                state_n = IDLE;
                code_n  = 3'd0;
            end
        end
    end

    assign cmd_valid = state == PENDING;
    assign cmd_code  = code;
    assign btn_level = stable;
endmodule

// File: tb/tb_move_command_encoder.sv
// tb_move_command_encoder: directed scenarios plus randomized button traffic, all
// checked every cycle against a window-based behavioural model of the encoder.
module tb_move_command_encoder;
    localparam int D = 4;
    // command code per button index {right, left, down, up, start}
    localparam logic [2:0] CODES [5] = '{3'd2, 3'd1, 3'd4, 3'd3, 3'd5};

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [4:0] pins = '1;
    logic cmd_ready = 1'b0;
    logic cmd_valid, cmd_dropped;
    logic [2:0] cmd_code;
    logic [4:0] btn_level;

    int checks = 0;
    int failures = 0;

    move_command_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(4), .BTN_ACTIVE_LOW(1'b1)) dut (
        .clk(clk), .rst(rst),
        .btn_start(pins[4]), .btn_left(pins[1]), .btn_right(pins[0]),
        .btn_up(pins[3]), .btn_down(pins[2]),
        .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
        .cmd_dropped(cmd_dropped), .btn_level(btn_level)
    );

    always #5 clk = ~clk;

    // Model: hist[j] holds the pressed vector sampled j+1 edges ago; the debouncer sees
    // samples two edges old, and a level flips once D consecutive seen samples disagree.
    logic [4:0] hist [8];
    logic [4:0] m_stable, m_prev, m_armed, m_ev;
    logic m_valid, m_drop;
    logic [2:0] m_code;
    int m_edges;
    logic [9:0] dut_out, mdl_out;

    function automatic logic [4:0] next_stable();
        logic [4:0] ns;
        ns = m_stable;
        for (int b = 0; b < 5; b++) begin
            bit all_diff = 1'b1;
            for (int j = 0; j < D; j++) if (hist[1 + j][b] == m_stable[b]) all_diff = 1'b0;
            if (all_diff) ns[b] = ~m_stable[b];
        end
        return ns;
    endfunction

    function automatic logic [2:0] code_of(logic [4:0] ev);
        logic [2:0] c;
        c = 3'd0;
        for (int b = 0; b < 5; b++) if (ev[b]) c = CODES[b];
        return c;
    endfunction

    assign m_ev    = m_stable & ~m_prev & m_armed;
    assign m_drop  = m_valid ? (m_ev != 5'd0) : ($countones(m_ev) > 1);
    assign dut_out = {cmd_valid, cmd_code, cmd_dropped, btn_level};
    assign mdl_out = {m_valid, m_code, m_drop, m_stable};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 8; i++) hist[i] <= '0;
            m_stable <= '0;
            m_prev   <= '0;
            m_armed  <= '0;
            m_valid  <= 1'b0;
            m_code   <= '0;
            m_edges  <= 0;
        end else begin
            hist[0] <= ~pins;
            for (int i = 1; i < 8; i++) hist[i] <= hist[i - 1];
            m_edges  <= (m_edges < 100) ? m_edges + 1 : m_edges;
            m_stable <= next_stable();
            m_prev   <= m_stable;
            if (m_edges >= 2) m_armed <= m_armed | (~hist[1] & ~m_stable);
            if (!m_valid && m_ev != 5'd0) begin
                m_valid <= 1'b1;
                m_code  <= code_of(m_ev);
            end else if (m_valid && cmd_ready) begin
                m_valid <= 1'b0;
                m_code  <= 3'd0;
            end
        end
    end

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (dut_out !== 10'd0) begin failures++; $display("FAIL reset_hold: got %b want 0", dut_out); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== 10'd0 || mdl_out !== 10'd0) begin
                failures++; $display("FAIL reset_idle: got %b model %b want 0", dut_out, mdl_out);
            end
        end
    endtask

    task automatic test_single_press();
        @(negedge clk);
        pins[1] = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL single_model k=%0d: got %b want %b", k, dut_out, mdl_out); end
            checks++;
            if (cmd_valid !== (k >= 7) || (k >= 7 && cmd_code !== 3'd1)) begin
                failures++; $display("FAIL single_latency k=%0d: valid=%b code=%0d want valid=%b code=1", k, cmd_valid, cmd_code, k >= 7);
            end
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        checks++;
        if (cmd_valid !== 1'b0 || cmd_code !== 3'd0) begin
            failures++; $display("FAIL single_transfer: valid=%b code=%0d want 0 0", cmd_valid, cmd_code);
        end
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            checks++;
            if (cmd_valid !== 1'b0 || dut_out !== mdl_out) begin
                failures++; $display("FAIL single_no_repeat: got %b want %b", dut_out, mdl_out);
            end
        end
        pins[1] = 1'b1;
        for (int k = 0; k < D + 4; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL single_release: got %b want %b", dut_out, mdl_out); end
        end
    endtask

    task automatic test_bounce();
        int rises = 0;
        logic last_lvl = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL bounce_model c=%0d: got %b want %b", c, dut_out, mdl_out); end
            if (btn_level[3] && !last_lvl) rises++;
            last_lvl = btn_level[3];
            pins[3] = ((c / 2) % 2 == 0) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        pins[3] = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL bounce_model k=%0d: got %b want %b", k, dut_out, mdl_out); end
            checks++;
            if (cmd_valid !== (k >= 7) || (k >= 7 && cmd_code !== 3'd3)) begin
                failures++; $display("FAIL bounce_latency k=%0d: valid=%b code=%0d want valid=%b code=3", k, cmd_valid, cmd_code, k >= 7);
            end
            if (btn_level[3] && !last_lvl) rises++;
            last_lvl = btn_level[3];
        end
        checks++;
        if (rises !== 1) begin failures++; $display("FAIL bounce_level_rises: got %0d want 1", rises); end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        pins[3] = 1'b1;
        for (int k = 0; k < D + 4; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out || cmd_valid !== 1'b0) begin failures++; $display("FAIL bounce_after: got %b want %b", dut_out, mdl_out); end
        end
    endtask

    task automatic test_simultaneous();
        int drops = 0;
        @(negedge clk);
        pins[4] = 1'b0;
        pins[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL simul_model k=%0d: got %b want %b", k, dut_out, mdl_out); end
            checks++;
            if (cmd_dropped !== (k == 6)) begin failures++; $display("FAIL simul_drop k=%0d: got %b want %b", k, cmd_dropped, k == 6); end
            if (cmd_dropped) drops++;
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd5 || drops !== 1) begin
            failures++; $display("FAIL simul_code: valid=%b code=%0d drops=%0d want 1 5 1", cmd_valid, cmd_code, drops);
        end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        pins = '1;
        for (int k = 0; k < D + 4; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out || cmd_valid !== 1'b0) begin failures++; $display("FAIL simul_after: got %b want %b", dut_out, mdl_out); end
        end
    endtask

    task automatic test_busy_drop();
        int drops = 0;
        @(negedge clk);
        pins[0] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin failures++; $display("FAIL busy_setup: valid=%b code=%0d want 1 2", cmd_valid, cmd_code); end
        pins[2] = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out || cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin
                failures++; $display("FAIL busy_hold k=%0d: got %b want %b", k, dut_out, mdl_out);
            end
            if (cmd_dropped) drops++;
        end
        checks++;
        if (drops !== 1) begin failures++; $display("FAIL busy_drop_count: got %0d want 1", drops); end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out || cmd_valid !== 1'b0) begin failures++; $display("FAIL busy_no_down: got %b want %b", dut_out, mdl_out); end
        end
        pins = '1;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        pins[1] = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin failures++; $display("FAIL rstmid_setup: valid=%b code=%0d want 1 1", cmd_valid, cmd_code); end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_out !== 10'd0) begin failures++; $display("FAIL rstmid_async: got %b want 0", dut_out); end
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out || cmd_valid !== 1'b0) begin failures++; $display("FAIL rstmid_held k=%0d: got %b want %b", k, dut_out, mdl_out); end
        end
        checks++;
        if (btn_level[1] !== 1'b1) begin failures++; $display("FAIL rstmid_level: got %b want 1", btn_level[1]); end
        pins[1] = 1'b1;
        repeat (D + 4) @(negedge clk);
        pins[1] = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL rstmid_repress k=%0d: got %b want %b", k, dut_out, mdl_out); end
        end
        checks++;
        if (cmd_valid !== 1'b1 || cmd_code !== 3'd1) begin failures++; $display("FAIL rstmid_new_cmd: valid=%b code=%0d want 1 1", cmd_valid, cmd_code); end
        cmd_ready = 1'b1;
        @(negedge clk);
        cmd_ready = 1'b0;
        pins = '1;
        repeat (D + 4) @(negedge clk);
    endtask

    task automatic test_release_only();
        @(negedge clk);
        pins[0] = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        checks++;
        if (btn_level[0] !== 1'b1 || cmd_valid !== 1'b0) begin failures++; $display("FAIL relonly_held: level=%b valid=%b want 1 0", btn_level[0], cmd_valid); end
        pins[0] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL relonly_model k=%0d: got %b want %b", k, dut_out, mdl_out); end
            checks++;
            if (btn_level[0] !== (k < D + 2) || cmd_valid !== 1'b0) begin
                failures++; $display("FAIL relonly_level k=%0d: level=%b valid=%b want %b 0", k, btn_level[0], cmd_valid, k < D + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        pins[1] = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL b2b_model k=%0d: got %b want %b", k, dut_out, mdl_out); end
            if (k == 13) begin
                checks++;
                if (cmd_valid !== 1'b0) begin failures++; $display("FAIL b2b_gap: valid=%b want 0", cmd_valid); end
            end
            if (k == 14) begin
                checks++;
                if (cmd_valid !== 1'b1 || cmd_code !== 3'd2) begin failures++; $display("FAIL b2b_next: valid=%b code=%0d want 1 2", cmd_valid, cmd_code); end
            end
            if (k == 7) pins[0] = 1'b0;
            cmd_ready = (k == 12);
        end
        cmd_ready = 1'b1;
        pins = '1;
        repeat (D + 4) @(negedge clk);
        cmd_ready = 1'b0;
    endtask

    task automatic test_random();
        int hold [5] = '{0, 0, 0, 0, 0};
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            checks++;
            if (dut_out !== mdl_out) begin failures++; $display("FAIL random c=%0d: got %b want %b", c, dut_out, mdl_out); end
            for (int b = 0; b < 5; b++) begin
                if (hold[b] == 0) begin
                    pins[b] = 1'($urandom_range(0, 1));
                    hold[b] = int'($urandom_range(1, 8));
                end else begin
                    hold[b]--;
                end
            end
            cmd_ready = ($urandom_range(0, 3) == 0);
        end
        pins = '1;
        cmd_ready = 1'b1;
        repeat (D + 6) @(negedge clk);
        checks++;
        if (dut_out !== mdl_out || cmd_valid !== 1'b0) begin failures++; $display("FAIL random_drain: got %b want %b", dut_out, mdl_out); end
        cmd_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_simultaneous();
        test_busy_drop();
        test_back_to_back();
        test_reset_mid();
        test_release_only();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
